axi_lite_test_subordinate: RTL
==============================

Name: axi_lite_test_subordinate

Overview:
- AXI-Lite subordinate (responder) register bank: the far end of the VIO-driven AXI-Lite test master.
- Accepts single-beat writes and reads into NUM_REGS 32-bit registers, with AW and W accepted independently in any order.
- Provides configurable response latency and decode errors, so the master's timeout and error paths can be exercised on hardware.
- Sits behind the test master, or on any interconnect port, as a known-good target.

Parameters:
AXI_LITE_ADDR_WIDTH, 32, address width
AXI_LITE_DATA_WIDTH, 32, data width (fixed 32; byte lanes unused)
NUM_REGS, 8, number of word registers; index = addr >> 2
BRESP_DELAY, 0, cycles between write commit and bvalid (used only with macro)
RVALID_DELAY, 0, cycles between AR capture and rvalid (used only with macro)
CNT_WIDTH, 16, width of transaction counters

Ports:
clk  in  1  clock
ap_rst_n  in  1  reset, asynchronous, active-low
S_AXIL_awvalid  in  1  write address valid
S_AXIL_awready  out  1  write address ready
S_AXIL_awaddr  in  AXI_LITE_ADDR_WIDTH  write address
S_AXIL_wvalid  in  1  write data valid
S_AXIL_wready  out  1  write data ready
S_AXIL_wdata  in  AXI_LITE_DATA_WIDTH  write data
S_AXIL_bvalid  out  1  write response valid
S_AXIL_bready  in  1  write response ready
S_AXIL_bresp  out  2  write response
S_AXIL_arvalid  in  1  read address valid
S_AXIL_arready  out  1  read address ready
S_AXIL_araddr  in  AXI_LITE_ADDR_WIDTH  read address
S_AXIL_rvalid  out  1  read data valid
S_AXIL_rready  in  1  read data ready
S_AXIL_rdata  out  AXI_LITE_DATA_WIDTH  read data
S_AXIL_rresp  out  2  read response
o_write_count  out  CNT_WIDTH  completed B handshakes, wraps
o_read_count  out  CNT_WIDTH  completed R handshakes, wraps

Behaviour:
- Reset (async assert, sync release): all readies/valids 0, bresp=rresp=0, rdata=0, all regs=0, counters=0, FSMs IDLE, holding flags clear.
- Readies are registered; they rise on the first clk edge after ap_rst_n releases.
- Write FSM states WR_IDLE, WR_DELAY, WR_RESP.
- WR_IDLE: awready=!aw_held, wready=!w_held.
  - Handshake on AW or W latches addr or data, sets the held flag, and drops that ready next cycle.
  - Both may complete in the same cycle or any order, any separation.
- Both held: commit on the next edge.
  - In-range index: reg[index] <= wdata, bresp=OKAY(0).
  - Else: no register changes, bresp=SLVERR(2).
  - Go to WR_DELAY, or straight to WR_RESP when delay is 0 or the macro is absent.
- WR_RESP: bvalid=1, held stable until bready. On handshake: bvalid 0, held flags clear, o_write_count+1, back to WR_IDLE with readies 1 next cycle.
- Read FSM states RD_IDLE, RD_DELAY, RD_RESP.
  - RD_IDLE: arready=1.
  - AR handshake samples reg[index] into rdata (rresp OKAY), or rdata=0 / rresp SLVERR when out of range; arready drops.
- RD_RESP: rvalid=1; rdata/rresp stable until rready. On handshake: o_read_count+1, back to RD_IDLE.
- Minimum latency without delay: bvalid on the cycle after the later of AW/W, plus 1 (commit). rvalid on the cycle after AR.
- Address low 2 bits ignored; index >= NUM_REGS is out of range, including the upper address bits.
- Read and write FSMs are fully independent.
  - Read capture in the same edge as a commit to the same register returns the OLD value.
  - Read captured after the commit edge returns the new value.
- Counters wrap at 2^CNT_WIDTH-1 -> 0.
- Valid deassertion by the master before handshake is not legal AXI; no recovery required, state holds.
- Reset mid-transaction: everything returns to reset values immediately; partial AW/W is discarded; a pending bvalid/rvalid is dropped.

Optional Feature:
- AXIL_SUB_RESP_DELAY_EN defined: WR_DELAY/RD_DELAY count BRESP_DELAY/RVALID_DELAY cycles (counter loads 1, response when counter == delay) before entering the response state. A delay of 0 skips the delay state.
  - Setting delays above the master TIMEOUT_DELAY exercises master timeouts.
- Absent: delay states and counters are not compiled; response issues at minimum latency; delay parameters ignored.

Decomposition:
- Package axi_lite_test_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, wr_state_t and rd_state_t enums, MODE_READ/MODE_WRITE constants shared with the master.
- One sub-module, axi_lite_resp_delay: a counter with start/done, instantiated once per channel under the macro.

Test Plan:
1. Write addr 4 data 0x0F0F0F0F, AW and W same cycle, bready=1 -> bvalid 2 cycles later, bresp=0, reg[1]=0x0F0F0F0F, o_write_count=1.
2. AW at addr 8, then W 0xABCDABCD 5 cycles later -> awready low during wait, single commit, reg[2]=0xABCDABCD, bresp=0.
3. Read addr 4 after test 1 with rready held low 3 cycles -> rvalid held, rdata=0x0F0F0F0F stable, rresp=0; o_read_count increments only at handshake.
4. Write addr 0x40 data 0x1 (NUM_REGS=8) -> bresp=2, no register changes; read 0x40 -> rdata=0, rresp=2.
5. With AXIL_SUB_RESP_DELAY_EN, BRESP_DELAY=20, RVALID_DELAY=20 -> bvalid/rvalid appear exactly 20 cycles after commit/capture; master with TIMEOUT_DELAY=10 reports timeout.
6. Deassert ap_rst_n while bvalid=1 -> bvalid/readies 0 asynchronously, regs 0, counters 0; readies 1 one edge after release.

Source files
------------

// File: rtl/axi_lite_test_pkg.sv
// Shared definitions for the AXI-Lite test master / test subordinate pair:
// response codes, channel FSM state encodings and transfer-mode constants.
package axi_lite_test_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Transfer direction selector used by the test master's VIO interface.
    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_DELAY = 2'd1,
        WR_RESP  = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_DELAY = 2'd1,
        RD_RESP  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/axi_lite_resp_delay.sv
// Response delay counter for one AXI-Lite response channel.
// Only compiled when AXIL_SUB_RESP_DELAY_EN is defined; without it the
// subordinate answers at minimum latency and needs no counter at all.
// i_start loads the count with 1; o_done is high for the single cycle in
// which the count equals DELAY, so a response state entered on o_done
// begins exactly DELAY cycles after the i_start edge.
`ifdef AXIL_SUB_RESP_DELAY_EN
module axi_lite_resp_delay #(
    parameter int DELAY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_done
);

    localparam int CW = (DELAY > 1) ? $clog2(DELAY + 1) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_active;

    // Count from 1 up to DELAY after a start pulse, then go idle.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= CW'(1);
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == CW'(DELAY)) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_done = r_active && (r_cnt == CW'(DELAY));

endmodule
`endif

// File: rtl/axi_lite_test_subordinate.sv
// AXI-Lite test subordinate: NUM_REGS x 32-bit register bank with
// independent AW/W acceptance, OKAY/SLVERR decode, and transaction counters.
// Optional macro AXIL_SUB_RESP_DELAY_EN inserts BRESP_DELAY / RVALID_DELAY
// cycles before each response so a master's timeout path can be exercised.
module axi_lite_test_subordinate
    import axi_lite_test_pkg::*;
#(
    parameter int AXI_LITE_ADDR_WIDTH = 32,
    parameter int AXI_LITE_DATA_WIDTH = 32,
    parameter int NUM_REGS            = 8,
    parameter int BRESP_DELAY         = 0,
    parameter int RVALID_DELAY        = 0,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                           clk,
    input  logic                           ap_rst_n,
    input  logic                           S_AXIL_awvalid,
    output logic                           S_AXIL_awready,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] S_AXIL_awaddr,
    input  logic                           S_AXIL_wvalid,
    output logic                           S_AXIL_wready,
    input  logic [AXI_LITE_DATA_WIDTH-1:0] S_AXIL_wdata,
    output logic                           S_AXIL_bvalid,
    input  logic                           S_AXIL_bready,
    output logic [1:0]                     S_AXIL_bresp,
    input  logic                           S_AXIL_arvalid,
    output logic                           S_AXIL_arready,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] S_AXIL_araddr,
    output logic                           S_AXIL_rvalid,
    input  logic                           S_AXIL_rready,
    output logic [AXI_LITE_DATA_WIDTH-1:0] S_AXIL_rdata,
    output logic [1:0]                     S_AXIL_rresp,
    output logic [CNT_WIDTH-1:0]           o_write_count,
    output logic [CNT_WIDTH-1:0]           o_read_count
);

    localparam int WORD_W = AXI_LITE_ADDR_WIDTH - 2;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // ---------------- write channel state ----------------
    wr_state_t                      r_wr_state, w_wr_next, w_wr_after_commit;
    logic                           r_awready, r_wready;
    logic                           r_aw_held, r_w_held;
    logic [WORD_W-1:0]              r_aw_word;
    logic [AXI_LITE_DATA_WIDTH-1:0] r_wdata;
    logic [1:0]                     r_bresp;
    logic [CNT_WIDTH-1:0]           r_write_count;
    logic [AXI_LITE_DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // ---------------- read channel state ----------------
    rd_state_t                      r_rd_state, w_rd_next, w_rd_after_capture;
    logic                           r_arready;
    logic [AXI_LITE_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                     r_rresp;
    logic [CNT_WIDTH-1:0]           r_read_count;

    // Address decode: byte offset ignored, any word index >= NUM_REGS
    // (including one produced by upper address bits) is out of range.
    logic              w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_commit;
    logic [WORD_W-1:0] w_ar_word;
    logic              w_wr_in_range, w_rd_in_range;
    logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
    logic              w_unused_addr_lsbs;

    assign w_aw_hs  = S_AXIL_awvalid && r_awready;
    assign w_w_hs   = S_AXIL_wvalid && r_wready;
    assign w_b_hs   = (r_wr_state == WR_RESP) && S_AXIL_bready;
    assign w_ar_hs  = S_AXIL_arvalid && r_arready;
    assign w_r_hs   = (r_rd_state == RD_RESP) && S_AXIL_rready;
    assign w_commit = (r_wr_state == WR_IDLE) && r_aw_held && r_w_held;

    assign w_ar_word     = S_AXIL_araddr[AXI_LITE_ADDR_WIDTH-1:2];
    assign w_wr_in_range = (r_aw_word < WORD_W'(NUM_REGS));
    assign w_rd_in_range = (w_ar_word < WORD_W'(NUM_REGS));
    assign w_wr_idx      = r_aw_word[IDX_W-1:0];
    assign w_rd_idx      = w_ar_word[IDX_W-1:0];
    assign w_unused_addr_lsbs = ^{S_AXIL_awaddr[1:0], S_AXIL_araddr[1:0]};

`ifdef AXIL_SUB_RESP_DELAY_EN
    logic w_wr_delay_done, w_rd_delay_done;

    axi_lite_resp_delay #(.DELAY(BRESP_DELAY)) u_wr_delay (
        .clk     (clk),
        .rst_n   (ap_rst_n),
        .i_start (w_commit && (BRESP_DELAY > 0)),
        .o_done  (w_wr_delay_done)
    );

    axi_lite_resp_delay #(.DELAY(RVALID_DELAY)) u_rd_delay (
        .clk     (clk),
        .rst_n   (ap_rst_n),
        .i_start (w_ar_hs && (RVALID_DELAY > 0)),
        .o_done  (w_rd_delay_done)
    );

    assign w_wr_after_commit  = (BRESP_DELAY > 0) ? WR_DELAY : WR_RESP;
    assign w_rd_after_capture = (RVALID_DELAY > 0) ? RD_DELAY : RD_RESP;
`else
    localparam int unused_delay_params = BRESP_DELAY + RVALID_DELAY;
    assign w_wr_after_commit  = WR_RESP;
    assign w_rd_after_capture = RD_RESP;
`endif

    // Channel FSM state registers.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
            r_rd_state <= w_rd_next;
        end
    end

    // Next-state logic for both channels; they never interact.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_wr_next = r_wr_state;
        w_rd_next = r_rd_state;
        case (r_wr_state)
            WR_IDLE:  if (w_commit) w_wr_next = w_wr_after_commit;
`ifdef AXIL_SUB_RESP_DELAY_EN
            WR_DELAY: if (w_wr_delay_done) w_wr_next = WR_RESP;
`endif
            WR_RESP:  if (S_AXIL_bready) w_wr_next = WR_IDLE;
            default:  w_wr_next = WR_IDLE;
        endcase
        case (r_rd_state)
            RD_IDLE:  if (w_ar_hs) w_rd_next = w_rd_after_capture;
`ifdef AXIL_SUB_RESP_DELAY_EN
            RD_DELAY: if (w_rd_delay_done) w_rd_next = RD_RESP;
`endif
            RD_RESP:  if (S_AXIL_rready) w_rd_next = RD_IDLE;
            default:  w_rd_next = RD_IDLE;
        endcase
    end

    // AW/W acceptance: each channel latches once and holds until the B handshake.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_awready     <= 1'b0;
            r_wready      <= 1'b0;
            r_aw_held     <= 1'b0;
            r_w_held      <= 1'b0;
            r_aw_word     <= '0;
            r_wdata       <= '0;
            r_write_count <= '0;
        end else if (r_wr_state == WR_IDLE) begin
            if (w_aw_hs) begin
                r_aw_word <= S_AXIL_awaddr[AXI_LITE_ADDR_WIDTH-1:2];
                r_aw_held <= 1'b1;
            end
            if (w_w_hs) begin
                r_wdata  <= S_AXIL_wdata;
                r_w_held <= 1'b1;
            end
            r_awready <= !(r_aw_held || w_aw_hs);
            r_wready  <= !(r_w_held || w_w_hs);
        end else if (w_b_hs) begin
            r_aw_held     <= 1'b0;
            r_w_held      <= 1'b0;
            r_awready     <= 1'b1;
            r_wready      <= 1'b1;
            r_write_count <= r_write_count + 1'b1;
        end
    end

    // Commit the held write into the bank and fix the B response.
    // NOTE: the bank is reset because a known all-zero power-up image is
    // part of this target's contract; plain RAM would normally skip it.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_bresp <= RESP_OKAY;
        end else if (w_commit) begin
            if (w_wr_in_range) r_regs[w_wr_idx] <= r_wdata;
            r_bresp <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // AR acceptance and read capture; rdata/rresp hold until the R handshake.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_arready    <= 1'b0;
            r_rdata      <= '0;
            r_rresp      <= RESP_OKAY;
            r_read_count <= '0;
        end else if (r_rd_state == RD_IDLE) begin
            r_arready <= !w_ar_hs;
            if (w_ar_hs) begin
                r_rdata <= w_rd_in_range ? r_regs[w_rd_idx] : '0;
                r_rresp <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end else if (w_r_hs) begin
            r_arready    <= 1'b1;
            r_read_count <= r_read_count + 1'b1;
        end
    end

    assign S_AXIL_awready = r_awready;
    assign S_AXIL_wready  = r_wready;
    assign S_AXIL_bvalid  = (r_wr_state == WR_RESP);
    assign S_AXIL_bresp   = r_bresp;
    assign S_AXIL_arready = r_arready;
    assign S_AXIL_rvalid  = (r_rd_state == RD_RESP);
    assign S_AXIL_rdata   = r_rdata;
    assign S_AXIL_rresp   = r_rresp;
    assign o_write_count  = r_write_count;
    assign o_read_count   = r_read_count;

endmodule
